// File: rtl/x7seg_if.sv
// Bundle of the multiplexed 7-segment lines being snooped and the decoder's results.
// The master side is the display driver / observer; the slave side is the decoder.
interface x7seg_if;
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic [15:0] x;
    logic [3:0]  lit;
    logic        locked;
    logic        frame_valid;
    logic        frame_err;
    logic        sticky_err;

    modport master (
        output a_to_g, an,
        input  x, lit, locked, frame_valid, frame_err, sticky_err
    );

    modport slave (
        input  a_to_g, an,
        output x, lit, locked, frame_valid, frame_err, sticky_err
    );
endinterface

// File: rtl/x7seg_scan_decoder.sv
// Recovers the 16-bit value shown on a scanned 4-digit active-low 7-segment display
// by following the anode scan and decoding each digit's segment pattern.
module x7seg_scan_decoder #(
    parameter int unsigned STRICT = 1
) (
    input  logic   cclk,
    input  logic   clr,
    x7seg_if.slave bus
);

    logic [1:0]  slot_q, slot_d;
    logic        locked_q, locked_d;
    logic        active_q, active_d;
    logic        err_q, err_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  shadow_lit_q, shadow_lit_d;
    logic [15:0] x_q, x_d;
    logic [3:0]  lit_q, lit_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        sticky_q, sticky_d;

    logic [3:0]  an_n;
    logic        is_lit;
    logic        is_blank;
    logic [1:0]  k;
    logic [4:0]  dec;
    logic [3:0]  nib;
    logic        nib_lit;
    logic        smp_err;
    logic        frame_err_now;

    // Returns {recognised, nibble}; unknown patterns decode to 0.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = 5'h10;
            7'b1001111: decode = 5'h11;
            7'b0010010: decode = 5'h12;
            7'b0000110: decode = 5'h13;
            7'b1001100: decode = 5'h14;
            7'b0100100: decode = 5'h15;
            7'b0100000: decode = 5'h16;
            7'b0001111: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0000100: decode = 5'h19;
            7'b0001000: decode = 5'h1A;
            7'b1100000: decode = 5'h1B;
            7'b0110001: decode = 5'h1C;
            7'b1000010: decode = 5'h1D;
            7'b0110000: decode = 5'h1E;
            7'b0111000: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        an_n     = ~bus.an;
        is_blank = (an_n == 4'b0000);
        is_lit   = 1'b1;
        k        = 2'd0;
        case (an_n)
            4'b0001: k = 2'd0;
            4'b0010: k = 2'd1;
            4'b0100: k = 2'd2;
            4'b1000: k = 2'd3;
            default: is_lit = 1'b0;
        endcase
        dec = decode(bus.a_to_g);
    end

    always_comb begin
        slot_d        = slot_q + 2'd1;
        locked_d      = locked_q;
        active_d      = active_q;
        err_d         = err_q;
        shadow_d      = shadow_q;
        shadow_lit_d  = shadow_lit_q;
        x_d           = x_q;
        lit_d         = lit_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        sticky_d      = sticky_q;
        nib           = 4'h0;
        nib_lit       = 1'b0;
        smp_err       = 1'b0;
        frame_err_now = 1'b0;

        if (!locked_q) begin
            // Acquire lock from the first lit digit; its successor is expected next.
            if (is_lit) begin
                locked_d = 1'b1;
                slot_d   = k + 2'd1;
            end
        end else if (is_lit && (k != slot_q)) begin
            slot_d      = k + 2'd1;
            locked_d    = 1'b0;
            active_d    = 1'b0;
            frame_err_d = 1'b1;
            sticky_d    = 1'b1;
        end else begin
            if (is_lit) begin
                nib     = dec[3:0];
                nib_lit = 1'b1;
                smp_err = ~dec[4];
            end else if (is_blank) begin
                smp_err = (slot_q == 2'd0);
            end else begin
                smp_err = 1'b1;
            end

            shadow_d[{slot_q, 2'b00} +: 4] = nib;
            shadow_lit_d[slot_q]           = nib_lit;

            frame_err_now = (slot_q == 2'd0) ? smp_err : (err_q | smp_err);
            err_d         = frame_err_now;

            if (slot_q == 2'd0)
                active_d = 1'b1;

            // Only a frame that started at slot 0 under lock may be reported.
            if (slot_q == 2'd3) begin
                active_d = 1'b0;
                if (active_q) begin
                    if (frame_err_now) begin
                        frame_err_d = 1'b1;
                        sticky_d    = 1'b1;
                    end
                    if (!frame_err_now || (STRICT == 0)) begin
                        x_d           = {nib, shadow_q[11:0]};
                        lit_d         = {nib_lit, shadow_lit_q[2:0]};
                        frame_valid_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge cclk or posedge clr) begin
        if (clr) begin
            slot_q        <= 2'd0;
            locked_q      <= 1'b0;
            active_q      <= 1'b0;
            err_q         <= 1'b0;
            shadow_q      <= 16'h0000;
            shadow_lit_q  <= 4'h0;
            x_q           <= 16'h0000;
            lit_q         <= 4'h0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            sticky_q      <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            locked_q      <= locked_d;
            active_q      <= active_d;
            err_q         <= err_d;
            shadow_q      <= shadow_d;
            shadow_lit_q  <= shadow_lit_d;
            x_q           <= x_d;
            lit_q         <= lit_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            sticky_q      <= sticky_d;
        end
    end

    assign bus.x           = x_q;
    assign bus.lit         = lit_q;
    assign bus.locked      = locked_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.sticky_err  = sticky_q;

endmodule

// File: tb/tb_x7seg_scan_decoder.sv
// Directed bench: a simple scan-driver model feeds the decoder and results are checked
// with immediate assertions after each clock edge.
module tb_x7seg_scan_decoder;

    logic cclk;
    logic clr;
    int   n_checks;
    int   n_fail;

    x7seg_if bus();

    x7seg_scan_decoder #(.STRICT(1)) dut (
        .cclk (cclk),
        .clr  (clr),
        .bus  (bus)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: seg_of = 7'b0000001;
            4'h1: seg_of = 7'b1001111;
            4'h2: seg_of = 7'b0010010;
            4'h3: seg_of = 7'b0000110;
            4'h4: seg_of = 7'b1001100;
            4'h5: seg_of = 7'b0100100;
            4'h6: seg_of = 7'b0100000;
            4'h7: seg_of = 7'b0001111;
            4'h8: seg_of = 7'b0000000;
            4'h9: seg_of = 7'b0000100;
            4'hA: seg_of = 7'b0001000;
            4'hB: seg_of = 7'b1100000;
            4'hC: seg_of = 7'b0110001;
            4'hD: seg_of = 7'b1000010;
            4'hE: seg_of = 7'b0110000;
            default: seg_of = 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_raw(input logic [3:0] an, input logic [6:0] seg);
        bus.an     = an;
        bus.a_to_g = seg;
        @(posedge cclk);
        #1;
        $display("t=%0t an=%b seg=%b -> x=%h lit=%b locked=%b fv=%b fe=%b se=%b",
                 $time, an, seg, bus.x, bus.lit, bus.locked, bus.frame_valid,
                 bus.frame_err, bus.sticky_err);
    endtask

    // Drive digit k of value v; blanked digits release all anodes.
    task automatic step_digit(input int k, input logic [15:0] v, input logic [3:0] blank);
        logic [3:0] an;
        an = ~(4'b0001 << k);
        if (blank[k])
            step_raw(4'b1111, 7'b1111111);
        else
            step_raw(an, seg_of(v[4*k +: 4]));
    endtask

    task automatic frame(input logic [15:0] v, input logic [3:0] blank);
        for (int d = 0; d < 4; d++)
            step_digit(d, v, blank);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_x"}, {16'h0, bus.x}, 32'h0);
        chk({tag, "_lit"}, {28'h0, bus.lit}, 32'h0);
        chk({tag, "_flags"}, {28'h0, bus.locked, bus.frame_valid, bus.frame_err, bus.sticky_err}, 32'h0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        clr        = 1'b1;
        bus.an     = 4'b1111;
        bus.a_to_g = 7'b1111111;
        @(posedge cclk);
        #1;
        chk_zero("reset");
        clr = 1'b0;

        // 0123 with digit 3 blank; lock on digit 0, partial first frame.
        step_digit(0, 16'h0123, 4'b1000);
        chk("lock_first", {31'h0, bus.locked}, 32'h1);
        step_digit(1, 16'h0123, 4'b1000);
        step_digit(2, 16'h0123, 4'b1000);
        step_digit(3, 16'h0123, 4'b1000);
        chk("partial_fv", {31'h0, bus.frame_valid}, 32'h0);
        chk("partial_fe", {31'h0, bus.frame_err}, 32'h0);
        frame(16'h0123, 4'b1000);
        chk("f0123_fv", {31'h0, bus.frame_valid}, 32'h1);
        chk("f0123_x", {16'h0, bus.x}, 32'h0123);
        chk("f0123_lit", {28'h0, bus.lit}, 32'h7);
        step_digit(0, 16'h0005, 4'b1110);
        chk("fv_pulse_end", {31'h0, bus.frame_valid}, 32'h0);
        step_digit(1, 16'h0005, 4'b1110);
        step_digit(2, 16'h0005, 4'b1110);
        step_digit(3, 16'h0005, 4'b1110);
        frame(16'h0005, 4'b1110);
        chk("f0005_x", {16'h0, bus.x}, 32'h0005);
        chk("f0005_lit", {28'h0, bus.lit}, 32'h1);
        chk("f0005_fe", {30'h0, bus.frame_err, bus.sticky_err}, 32'h0);

        // Unknown segment pattern on slot 2.
        step_digit(0, 16'h0123, 4'b1000);
        step_digit(1, 16'h0123, 4'b1000);
        step_raw(4'b1011, 7'b1111111);
        step_digit(3, 16'h0123, 4'b1000);
        chk("segerr_fe", {31'h0, bus.frame_err}, 32'h1);
        chk("segerr_fv", {31'h0, bus.frame_valid}, 32'h0);
        chk("segerr_sticky", {31'h0, bus.sticky_err}, 32'h1);
        chk("segerr_xhold", {16'h0, bus.x}, 32'h0005);
        frame(16'h0123, 4'b1000);
        chk("segrec_fv", {31'h0, bus.frame_valid}, 32'h1);
        chk("segrec_x", {16'h0, bus.x}, 32'h0123);

        // Two anodes low on slot 1.
        step_digit(0, 16'h4567, 4'b0000);
        step_raw(4'b0011, seg_of(4'h6));
        step_digit(2, 16'h4567, 4'b0000);
        step_digit(3, 16'h4567, 4'b0000);
        chk("multi_fe", {31'h0, bus.frame_err}, 32'h1);
        chk("multi_xhold", {16'h0, bus.x}, 32'h0123);
        frame(16'h4567, 4'b0000);
        chk("f4567_x", {16'h0, bus.x}, 32'h4567);
        chk("f4567_lit", {28'h0, bus.lit}, 32'hF);

        // Scan skips digit 2.
        step_digit(0, 16'h89AB, 4'b0000);
        step_digit(1, 16'h89AB, 4'b0000);
        step_digit(3, 16'h89AB, 4'b0000);
        chk("sync_locked", {31'h0, bus.locked}, 32'h0);
        chk("sync_fe", {31'h0, bus.frame_err}, 32'h1);
        step_digit(0, 16'h89AB, 4'b0000);
        chk("relock", {31'h0, bus.locked}, 32'h1);
        chk("sync_fe_pulse", {31'h0, bus.frame_err}, 32'h0);
        step_digit(1, 16'h89AB, 4'b0000);
        step_digit(2, 16'h89AB, 4'b0000);
        step_digit(3, 16'h89AB, 4'b0000);
        chk("sync_partial_fv", {31'h0, bus.frame_valid}, 32'h0);
        chk("sync_xhold", {16'h0, bus.x}, 32'h4567);
        frame(16'h89AB, 4'b0000);
        chk("f89ab_fv", {31'h0, bus.frame_valid}, 32'h1);
        chk("f89ab_x", {16'h0, bus.x}, 32'h89AB);

        // Reset asserted while slot 2 is on the lines.
        step_digit(0, 16'hCDEF, 4'b0000);
        step_digit(1, 16'hCDEF, 4'b0000);
        bus.an     = 4'b1011;
        bus.a_to_g = seg_of(4'hD);
        clr        = 1'b1;
        #1;
        chk_zero("midclr");
        @(posedge cclk);
        #1;
        clr = 1'b0;
        step_digit(3, 16'hCDEF, 4'b0000);
        chk("clr_relock", {31'h0, bus.locked}, 32'h1);
        chk("clr_relock_x", {16'h0, bus.x}, 32'h0);
        frame(16'hCDEF, 4'b0000);
        chk("fcdef_x", {16'h0, bus.x}, 32'hCDEF);
        chk("fcdef_lit", {28'h0, bus.lit}, 32'hF);
        chk("fcdef_flags", {29'h0, bus.frame_valid, bus.frame_err, bus.sticky_err}, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
